uart_rx: RTL and testbench

Receives asynchronous serial frames, 8 data bits LSB-first with 1 stop bit, on `serial_rx`. It is the receive-side counterpart of the platform UART transmitter and shares its CLOCK_FREQUENCY/BAUD_RATE timing model. It oversamples with the system clock, samples each bit at mid-bit and presents each byte with a one-cycle valid pulse. It sits in the UART I/O block and feeds the MMIO/receive FIFO logic.

---
 rtl/uart_rx.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : asynchronous serial receiver, 8 data bits LSB-first, 1 stop bit.
//
// The line is oversampled with the system clock. A falling edge on the
// synchronized line starts a frame. The start bit is re-checked at mid-bit,
// and every following bit is sampled at its centre. Each good byte is
// presented with a one-cycle rx_valid pulse.
//
// Optional feature (macro UART_RX_PARITY_EN): one parity bit is inserted
// between the data bits and the stop bit. PARITY_ODD selects odd (1) or even
// (0) parity. Without the macro the framing is 8N1 and rx_parity_error is 0.
//
// Ports:
//   clock           in   system clock, all logic on posedge
//   reset           in   asynchronous, active-low reset
//   serial_rx       in   asynchronous serial line, idle high
//   rx_data         out  [7:0] last correctly received byte
//   rx_valid        out  one-cycle pulse, rx_data updated in the same cycle
//   rx_busy         out  high whenever the receiver is not idle
//   rx_frame_error  out  one-cycle pulse when the stop bit samples low
//   rx_parity_error out  one-cycle pulse on parity mismatch
// ============================================================================
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 9600,
    parameter int PARITY_ODD      = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_error,
    output logic       rx_parity_error
);

    localparam int          CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam logic [15:0] BIT_LAST       = 16'(CLOCKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST      = 16'(CLOCKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic        rx_sync;
    logic [15:0] count_q, count_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_frame_error_q, rx_frame_error_d;
    logic        bit_last;

`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
    logic        rx_parity_error_q, rx_parity_error_d;
    logic        par_expected;

    // Even parity: the parity bit equals the XOR of the data bits.
    assign par_expected = (^shift_q) ^ (PARITY_ODD != 0);
`else
    logic        unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    assign rx_sync  = sync2_q;
    assign bit_last = (count_q == BIT_LAST);

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_rx;
            sync2_q <= sync1_q;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_sync) state_d = S_START;
            end
            S_START: begin
                // A start bit that is high again at its centre was a glitch.
                if (count_q == HALF_LAST) state_d = rx_sync ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_last && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_last) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop gives half a bit of slack to catch the
                // next start edge of a back-to-back frame.
                if (bit_last) state_d = rx_sync ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                // Hold here while the line stays low so a break reports once.
                if (rx_sync) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        count_d          = count_q;
        shift_d          = shift_q;
        bit_idx_d        = bit_idx_q;
        rx_data_d        = rx_data_q;
        rx_valid_d       = 1'b0;
        rx_frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d         = par_bad_q;
        rx_parity_error_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                count_d   = 16'd0;
                bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
            S_START: begin
                if (count_q == HALF_LAST) begin
                    count_d   = 16'd0;
                    bit_idx_d = 3'd0;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    count_d   = 16'd0;
                    // Shift right: the first (LSB) bit ends up in bit 0.
                    shift_d   = {rx_sync, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_last) begin
                    count_d   = 16'd0;
                    par_bad_d = (rx_sync != par_expected);
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_last) begin
                    count_d = 16'd0;
                    if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            rx_parity_error_d = 1'b1;
                        end else begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = shift_q;
                        end
`else
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
`endif
                    end else begin
                        // A bad stop bit outranks any parity mismatch.
                        rx_frame_error_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            S_BREAK: begin
                count_d = 16'd0;
            end
            default: begin
                count_d   = 16'd0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q          <= 16'd0;
            shift_q          <= 8'd0;
            bit_idx_q        <= 3'd0;
            rx_data_q        <= 8'd0;
            rx_valid_q       <= 1'b0;
            rx_frame_error_q <= 1'b0;
        end else begin
            count_q          <= count_d;
            shift_q          <= shift_d;
            bit_idx_q        <= bit_idx_d;
            rx_data_q        <= rx_data_d;
            rx_valid_q       <= rx_valid_d;
            rx_frame_error_q <= rx_frame_error_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            par_bad_q         <= 1'b0;
            rx_parity_error_q <= 1'b0;
        end else begin
            par_bad_q         <= par_bad_d;
            rx_parity_error_q <= rx_parity_error_d;
        end
    end

    assign rx_parity_error = rx_parity_error_q;
`else
    assign rx_parity_error = 1'b0;
`endif

    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign rx_frame_error = rx_frame_error_q;
    assign rx_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : scoreboard bench for uart_rx with 16 clocks per bit.
// Stimulus pushes the expected pulse (kind + rx_data) before driving a frame;
// a monitor process pops and compares whenever a pulse appears.
// ============================================================================
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int K_VAL = 0;
    localparam int K_FER = 1;
    localparam int K_PER = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       serial_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_error;
    logic       rx_parity_error;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    int   valid_times[$];

    uart_rx #(
        .CLOCK_FREQUENCY(16),
        .BAUD_RATE      (1),
        .PARITY_ODD     (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .serial_rx      (serial_rx),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_busy        (rx_busy),
        .rx_frame_error (rx_frame_error),
        .rx_parity_error(rx_parity_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_rx = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    task automatic push(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        check(name, sb.size(), 0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (rx_valid || rx_frame_error || rx_parity_error) begin
                int   n;
                int   kind;
                exp_t e;
                n    = int'(rx_valid) + int'(rx_frame_error) + int'(rx_parity_error);
                kind = rx_valid ? K_VAL : (rx_frame_error ? K_FER : K_PER);
                check("pulse_exclusive", n, 1);
                if (rx_valid) valid_times.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", kind, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", kind, e.kind);
                    check("pulse_rx_data", rx_data, e.data);
                end
            end
        end
    endtask

    initial begin
        int busy_cnt;
        int gap;

        fork
            monitor();
        join_none

        reset     = 1'b0;
        serial_rx = 1'b1;
        repeat (3) tick();
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_frame_err", rx_frame_error, 0);
        check("reset_parity_err", rx_parity_error, 0);
        reset = 1'b1;
        repeat (CPB) tick();

        // Single frame
        push(K_VAL, 8'h55);
        send_frame(8'h55, 1'b1);
        check("busy_low_by_stop_end", rx_busy, 0);
        drain("drain_55");
        repeat (CPB) tick();

        // Back-to-back frames, no idle gap
        valid_times.delete();
        push(K_VAL, 8'hA3);
        push(K_VAL, 8'h3C);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
        drain("drain_b2b");
        check("b2b_valid_count", valid_times.size(), 2);
        if (valid_times.size() == 2) begin
            gap = valid_times[1] - valid_times[0];
            check("b2b_gap_in_159_161", (gap >= 159 && gap <= 161), 1);
        end
        repeat (CPB) tick();

        // Glitch: 5 low cycles
        busy_cnt  = 0;
        serial_rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rx_busy) busy_cnt++;
        end
        serial_rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rx_busy) busy_cnt++;
        end
        check("glitch_busy_7_to_9", (busy_cnt >= 7 && busy_cnt <= 9), 1);
        check("glitch_back_idle", rx_busy, 0);
        check("glitch_rx_data_kept", rx_data, 8'h3C);
        repeat (CPB) tick();

        // Low stop bit then held low: one frame error, data unchanged
        push(K_FER, 8'h3C);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        serial_rx = 1'b0;
        repeat (40) tick();
        serial_rx = 1'b1;
        repeat (2 * CPB) tick();
        check("break_idle_again", rx_busy, 0);
        push(K_VAL, 8'h12);
        send_frame(8'h12, 1'b1);
        drain("drain_break");
        repeat (CPB) tick();

        // Reset during bit 4 of 0x81, then a clean 0x7E
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        serial_rx = 1'b0;
        repeat (8) tick();
        reset     = 1'b0;
        serial_rx = 1'b1;
        tick();
        reset = 1'b1;
        check("midreset_rx_data", rx_data, 0);
        check("midreset_rx_busy", rx_busy, 0);
        repeat (2 * CPB) tick();
        check("midreset_no_pulse", sb.size(), 0);
        push(K_VAL, 8'h7E);
        send_frame(8'h7E, 1'b1);
        drain("drain_7e");
        repeat (CPB) tick();

`ifdef UART_RX_PARITY_EN
        push(K_VAL, 8'h07);
        send_frame_par(8'h07, 1'b1);
        drain("drain_par_good");
        repeat (CPB) tick();
        push(K_PER, 8'h07);
        send_frame_par(8'h07, 1'b0);
        drain("drain_par_bad");
        repeat (CPB) tick();
`endif

        repeat (4 * CPB) tick();
        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
